// File: rtl/axi3_rd_arbiter.sv
// rtl/axi3_rd_arbiter.sv - round-robin arbiter sharing one AXI3 read master between two cache requesters
module axi3_rd_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   m0_arid,
  input  logic [ADDR_WIDTH-1:0] m0_araddr,
  input  logic [LEN_WIDTH-1:0]  m0_arlen,
  input  logic [2:0]            m0_arsize,
  input  logic [1:0]            m0_arburst,
  input  logic                  m0_arvalid,
  output logic                  m0_arready,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic [1:0]            m0_rresp,
  output logic [ID_WIDTH-1:0]   m0_rid,
  output logic                  m0_rlast,
  output logic                  m0_rvalid,
  input  logic                  m0_rready,
  input  logic [ID_WIDTH-1:0]   m1_arid,
  input  logic [ADDR_WIDTH-1:0] m1_araddr,
  input  logic [LEN_WIDTH-1:0]  m1_arlen,
  input  logic [2:0]            m1_arsize,
  input  logic [1:0]            m1_arburst,
  input  logic                  m1_arvalid,
  output logic                  m1_arready,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [1:0]            m1_rresp,
  output logic [ID_WIDTH-1:0]   m1_rid,
  output logic                  m1_rlast,
  output logic                  m1_rvalid,
  input  logic                  m1_rready,
  output logic [ID_WIDTH-1:0]   axi_arid,
  output logic [ADDR_WIDTH-1:0] axi_araddr,
  output logic [LEN_WIDTH-1:0]  axi_arlen,
  output logic [2:0]            axi_arsize,
  output logic [1:0]            axi_arburst,
  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  input  logic [ID_WIDTH-1:0]   axi_rid,
  input  logic [DATA_WIDTH-1:0] axi_rdata,
  input  logic [1:0]            axi_rresp,
  input  logic                  axi_rlast,
  input  logic                  axi_rvalid,
  output logic                  axi_rready
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  prio_q, prio_d;
  logic [ID_WIDTH-1:0]   arid_q, arid_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [LEN_WIDTH-1:0]  arlen_q, arlen_d;
  logic [2:0]            arsize_q, arsize_d;
  logic [1:0]            arburst_q, arburst_d;

  logic any_req;
  logic gnt;
  logic in_data;
  logic r_fire;

  // A tie goes to prio_q; a lone requester always wins.
  assign any_req = m0_arvalid | m1_arvalid;
  assign gnt     = (m0_arvalid & m1_arvalid) ? prio_q : m1_arvalid;
  assign in_data = (state_q == DATA);
  assign r_fire  = axi_rvalid & axi_rready;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    prio_d     = prio_q;
    arid_d     = arid_q;
    araddr_d   = araddr_q;
    arlen_d    = arlen_q;
    arsize_d   = arsize_q;
    arburst_d  = arburst_q;
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req && !rst) begin
          m0_arready = ~gnt;
          m1_arready = gnt;
          owner_d    = gnt;
          state_d    = ADDR;
          if (gnt) begin
            arid_d    = m1_arid;
            araddr_d  = m1_araddr;
            arlen_d   = m1_arlen;
            arsize_d  = m1_arsize;
            arburst_d = m1_arburst;
          end else begin
            arid_d    = m0_arid;
            araddr_d  = m0_araddr;
            arlen_d   = m0_arlen;
            arsize_d  = m0_arsize;
            arburst_d = m0_arburst;
          end
        end
      end
      ADDR: begin
        if (axi_arready) state_d = DATA;
      end
      DATA: begin
        if (r_fire && axi_rlast) begin
          state_d = IDLE;
          prio_d  = ~owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      prio_q    <= 1'b0;
      arid_q    <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      prio_q    <= prio_d;
      arid_q    <= arid_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arsize_q  <= arsize_d;
      arburst_q <= arburst_d;
    end
  end

  assign axi_arid    = arid_q;
  assign axi_araddr  = araddr_q;
  assign axi_arlen   = arlen_q;
  assign axi_arsize  = arsize_q;
  assign axi_arburst = arburst_q;
  assign axi_arvalid = (state_q == ADDR);

  // R backpressure goes straight through from the owner; nothing is buffered.
  assign axi_rready = in_data & (owner_q ? m1_rready : m0_rready);

  assign m0_rvalid = in_data & ~owner_q & axi_rvalid;
  assign m1_rvalid = in_data &  owner_q & axi_rvalid;
  assign m0_rlast  = in_data & ~owner_q & axi_rlast;
  assign m1_rlast  = in_data &  owner_q & axi_rlast;
  assign m0_rdata  = axi_rdata;
  assign m1_rdata  = axi_rdata;
  assign m0_rresp  = axi_rresp;
  assign m1_rresp  = axi_rresp;
  assign m0_rid    = axi_rid;
  assign m1_rid    = axi_rid;

endmodule
